// File: rtl/ysyx_22050598_muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the op encoding, the FSM state type and the W-result sign-extension helper.
package ysyx_22050598_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Sign-extend a 32-bit W result to 64 bits.
  function automatic logic [63:0] sext_w(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/ysyx_22050598_div_step.sv
// One restoring-division step (combinational).
// Ports: rem/quot/divisor  current partial remainder, dividend-shift/quotient register, divisor magnitude
//        rem_next/quot_next  values after shifting in one dividend bit and retiring one quotient bit
module ysyx_22050598_div_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  assign shifted = {rem, quot[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  // rem < divisor always holds, so |diff| < 2^XLEN and the top bit is the borrow.
  assign ge        = ~diff[XLEN];
  assign rem_next  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quot_next = {quot[XLEN-2:0], ge};

endmodule

// File: rtl/ysyx_22050598_exu_muldiv_seq.sv
// Iterative multiply/divide unit for the EXU (RV64M incl. W ops).
// Ports: clk, rst (async, active-high), flush (kills in-flight op)
//        in_valid/in_ready + op/op_w/rs1/rs2  request handshake
//        out_valid/out_ready + result          response handshake
module ysyx_22050598_exu_muldiv_seq
  import ysyx_22050598_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MUL_STEP = 2,
  parameter bit          W_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam bit          W_OK  = W_EN && (XLEN == 64);
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              w_q, sgn_a_q, neg_q;
  logic [PW-1:0]     acc_q, acc_n, mcand_q;
  logic [XLEN-1:0]   mplier_q, rem_q, quot_q, dsor_q, rem_n, quot_n;

  // Request decode and operand conditioning
  logic            is_div, w_c, a_sgn_op, b_sgn_op, sgn_a, sgn_b;
  logic            div_zero, ovf, special, accept;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, dvd_res, special_res;
  logic [CNT_W-1:0] n_load;

  assign is_div   = op[2];
  assign w_c      = W_OK && op_w && (is_div || (op == OP_MUL));
  assign a_sgn_op = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign b_sgn_op = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);

  assign a_ext = w_c ? (a_sgn_op ? XLEN'(sext_w(rs1[31:0])) : XLEN'(rs1[31:0])) : rs1;
  assign b_ext = w_c ? (b_sgn_op ? XLEN'(sext_w(rs2[31:0])) : XLEN'(rs2[31:0])) : rs2;
  assign sgn_a = a_sgn_op & a_ext[XLEN-1];
  assign sgn_b = b_sgn_op & b_ext[XLEN-1];
  assign mag_a = sgn_a ? -a_ext : a_ext;
  assign mag_b = sgn_b ? -b_ext : b_ext;

  assign div_zero = is_div && (b_ext == '0);
  assign ovf      = is_div && !op[0] && (b_ext == '1) &&
                    (a_ext == (w_c ? XLEN'(sext_w(32'h8000_0000)) : MOST_NEG));
  assign special  = div_zero || ovf;

  // Special-case results; W results are always sign-extended from bit 31.
  assign dvd_res = w_c ? XLEN'(sext_w(rs1[31:0])) : rs1;
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? dvd_res : '1;
    else          special_res = op[1] ? '0 : dvd_res;
  end

  assign n_load = is_div ? CNT_W'(w_c ? WORD_W : XLEN)
                         : CNT_W'((w_c ? WORD_W : XLEN) / MUL_STEP);

  assign in_ready = (state_q == S_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Shift-add: retire MUL_STEP multiplier bits per cycle
  always_comb begin
    acc_n = acc_q;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) acc_n = acc_n + (mcand_q << i);
    end
  end

  ysyx_22050598_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_q),
    .quot     (quot_q),
    .divisor  (dsor_q),
    .rem_next (rem_n),
    .quot_next(quot_n)
  );

  // Sign fix-up and result selection
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quo, rmd, fix_res;

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -quot_q : quot_q;
  assign rmd  = sgn_a_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[PW-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo;
      default:                      fix_res = rmd;
    endcase
    if (w_q) fix_res = XLEN'(sext_w(fix_res[31:0]));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       if (in_valid) state_d = special ? S_DONE : (is_div ? S_DIV : S_MUL);
        S_MUL, S_DIV: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        S_FIX:        state_d = S_DONE;
        S_DONE:       if (out_valid && out_ready) state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      w_q      <= 1'b0;
      sgn_a_q  <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dsor_q   <= '0;
      result   <= '0;
    end else if (accept) begin
      op_q     <= op;
      w_q      <= w_c;
      sgn_a_q  <= sgn_a;
      neg_q    <= sgn_a ^ sgn_b;
      cnt_q    <= n_load;
      acc_q    <= '0;
      mcand_q  <= PW'(mag_a);
      mplier_q <= mag_b;
      rem_q    <= '0;
      // W dividends are pre-aligned to the top so 32 steps consume them.
      quot_q   <= w_c ? (mag_a << WORD_W) : mag_a;
      dsor_q   <= mag_b;
      if (special) result <= special_res;
    end else begin
      case (state_q)
        S_MUL: begin
          acc_q    <= acc_n;
          mcand_q  <= mcand_q << MUL_STEP;
          mplier_q <= mplier_q >> MUL_STEP;
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        S_DIV: begin
          rem_q  <= rem_n;
          quot_q <= quot_n;
          cnt_q  <= cnt_q - CNT_W'(1);
        end
        S_FIX:   result <= fix_res;
        default: ;
      endcase
    end
  end

  // out_valid rises one edge after entering DONE and drops on handshake or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= (state_q == S_DONE) && !flush && !(out_valid && out_ready);
  end

endmodule

// File: tb/tb_ysyx_22050598_exu_muldiv_seq.sv
// Scoreboard bench for the sequential multiply/divide unit (XLEN=64, MUL_STEP=2).
module tb_ysyx_22050598_exu_muldiv_seq;
  import ysyx_22050598_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, op_w, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] rs1, rs2, result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rdy_pct = 100;
  bit seen = 1'b0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  ysyx_22050598_exu_muldiv_seq #(.XLEN(64), .MUL_STEP(2), .W_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_w(op_w), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference model: plain wide arithmetic plus the RISC-V special-case rules.
  function automatic void model(input logic [2:0] o, input logic w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r, output int lat);
    logic [127:0] ea, eb, p;
    logic [63:0]  da, db;
    bit           wd, sg, ov;
    wd = w && ((o == OP_MUL) || o[2]);
    if (!o[2]) begin
      ea  = (o == OP_MULHU) ? {64'd0, a} : {{64{a[63]}}, a};
      eb  = ((o == OP_MUL) || (o == OP_MULH)) ? {{64{b[63]}}, b} : {64'd0, b};
      p   = ea * eb;
      r   = (o == OP_MUL) ? p[63:0] : p[127:64];
      lat = (wd ? 32 : 64) / 2 + 2;
    end else begin
      sg  = !o[0];
      da  = wd ? (sg ? sx(a[31:0]) : {32'd0, a[31:0]}) : a;
      db  = wd ? (sg ? sx(b[31:0]) : {32'd0, b[31:0]}) : b;
      ov  = sg && (db == '1) && (da == (wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      lat = ((db == 64'd0) || ov) ? 1 : (wd ? 32 : 64) + 2;
      if (db == 64'd0)  r = o[1] ? da : '1;
      else if (ov)      r = o[1] ? 64'd0 : da;
      else if (sg)      r = o[1] ? 64'($signed(da) % $signed(db)) : 64'($signed(da) / $signed(db));
      else              r = o[1] ? (da % db) : (da / db);
    end
    if (wd) r = sx(r[31:0]);
  endfunction

  // Drive one request and push its expected response once it is accepted.
  task automatic issue_exp(input logic [2:0] o, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] e, input int l);
    int t = 0;
    @(negedge clk);
    op = o; op_w = w; rs1 = a; rs2 = b; in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    lat_q.push_back(l);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic issue_rand(input logic [2:0] o, input logic w, input logic [63:0] a,
                            input logic [63:0] b);
    logic [63:0] e;
    int          l;
    model(o, w, a, b, e, l);
    issue_exp(o, w, a, b, e, l);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: outstanding got %0d expected 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); seen = 1'b0;
    end
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {$urandom, 32'h8000_0000};
      4:       return 64'($urandom_range(9));
      5:       return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: latency of first out_valid, hold under backpressure, result on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: out_valid got 1 expected 0 (result %h)", result);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 64'(cyc - acc_cyc), 64'(lat_q[0]));
        end
        check("in_ready_busy", 64'(in_ready), 64'd0);
        if (out_ready) begin
          check("result", result, exp_q.pop_front());
          void'(lat_q.pop_front());
          seen = 1'b0;
        end else begin
          check("result_hold", result, exp_q[0]);
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; op_w = 1'b0; rs1 = '0; rs2 = '0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed cases with hand-derived expectations
    issue_exp(OP_MUL,   1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 34);
    issue_exp(OP_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    issue_exp(OP_MULH,  1'b0, '1, '1, 64'h0, 34);
    issue_exp(OP_DIV,   1'b0, 64'd5, 64'd0, '1, 1);
    issue_exp(OP_REMU,  1'b0, 64'd5, 64'd0, 64'd5, 1);
    issue_exp(OP_DIV,   1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    issue_exp(OP_REM,   1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
    issue_exp(OP_DIV,   1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    issue_exp(OP_REM,   1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, '1, 34);
    issue_exp(OP_DIVU,  1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    drain();

    // Backpressure: hold out_ready low for 5 cycles in DONE
    rdy_pct = 0;
    issue_exp(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 34);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("valid_held", 64'(out_valid), 64'd1);
    rdy_pct = 100;
    drain();

    // Flush 10 cycles into a divide
    issue_exp(OP_DIV, 1'b0, 64'd1000, 64'd7, 64'd142, 66);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    exp_q.delete(); lat_q.delete(); seen = 1'b0;
    #1;
    check("in_ready_during_flush", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("in_ready_after_flush", 64'(in_ready), 64'd1);
    repeat (70) @(negedge clk);
    issue_exp(OP_MUL, 1'b0, 64'd123456789, 64'd1000, 64'd123456789000, 34);
    drain();

    // Flush coinciding with in_valid must not accept
    @(negedge clk);
    op = OP_DIVU; op_w = 1'b0; rs1 = 64'd9; rs2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_blocks_accept", 64'(in_ready), 64'd1);
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-operation
    issue_exp(OP_MULHU, 1'b0, '1, 64'd3, 64'd2, 34);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); lat_q.delete(); seen = 1'b0;
    #1;
    check("midop_reset_result", result, 64'd0);
    check("midop_reset_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_midop_reset", 64'(in_ready), 64'd1);

    // Randomized traffic with random backpressure
    rdy_pct = 70;
    for (int n = 0; n < 80; n++) begin
      issue_rand(3'($urandom_range(7)), 1'($urandom_range(1)), rnd_val(), rnd_val());
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
